// File: rtl/load_store_unit.sv
// load_store_unit: single-port data-memory load/store engine.
// Byte/halfword/word loads and stores, little-endian lanes, sub-word
// stores by read-merge-write.
// Ports: clk, rst (sync, active high); req_* CPU request with
// valid/ready handshake; resp_* one-cycle completion with load data
// and error; mem_* word-indexed memory with registered read data.
// Build option: define LSU_MISALIGN_TRAP_EN to reject misaligned
// halfword/word accesses and size 11 with resp_err; otherwise the
// address is force-aligned and size 11 acts as word.
module load_store_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  output logic        mem_W,
  output logic        mem_R,
  input  logic [31:0] mem_dout
);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    EXTRACT,
    MERGE,
    WRITE,
    RESP
  } state_t;

  state_t      state;
  logic [1:0]  a_off;
  logic [1:0]  a_size;
  logic        a_we;
  logic        a_uns;
  logic [31:0] a_wdata;

  logic        bad;
  logic [31:0] ld_val;
  logic [31:0] merged;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;

`ifdef LSU_MISALIGN_TRAP_EN
  always_comb begin
    bad = 1'b0;
    unique case (req_size)
      2'b01:   bad = req_addr[0];
      2'b10:   bad = |req_addr[1:0];
      2'b11:   bad = 1'b1;
      default: bad = 1'b0;
    endcase
  end
`else
  assign bad = 1'b0;
`endif

  // Lane select and extension; alignment bits below the access
  // size are simply not used, which forces alignment.
  always_comb begin
    ld_b   = mem_dout[{a_off, 3'b000} +: 8];
    ld_h   = mem_dout[{a_off[1], 4'b0000} +: 16];
    ld_val = mem_dout;
    merged = mem_dout;
    unique case (1'b1)
      a_size[1]: begin
        ld_val = mem_dout;
        merged = a_wdata;
      end
      (a_size == 2'b01): begin
        ld_val = {{16{ld_h[15] & ~a_uns}}, ld_h};
        merged[{a_off[1], 4'b0000} +: 16] = a_wdata[15:0];
      end
      (a_size == 2'b00): begin
        ld_val = {{24{ld_b[7] & ~a_uns}}, ld_b};
        merged[{a_off, 3'b000} +: 8] = a_wdata[7:0];
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= 32'd0;
      mem_W      <= 1'b0;
      mem_R      <= 1'b0;
      mem_addr   <= 32'd0;
      mem_din    <= 32'd0;
      a_off      <= 2'd0;
      a_size     <= 2'd0;
      a_we       <= 1'b0;
      a_uns      <= 1'b0;
      a_wdata    <= 32'd0;
    end else begin
      unique case (state)
        IDLE: begin
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          if (req_valid) begin
            req_ready <= 1'b0;
            a_off     <= req_addr[1:0];
            a_size    <= req_size;
            a_we      <= req_we;
            a_uns     <= req_unsigned;
            a_wdata   <= req_wdata;
            mem_addr  <= {2'b00, req_addr[31:2]};
            if (bad) begin
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              state      <= RESP;
            end else if (req_we && req_size[1]) begin
              mem_W   <= 1'b1;
              mem_din <= req_wdata;
              state   <= WRITE;
            end else begin
              mem_R <= 1'b1;
              state <= READ;
            end
          end
        end
        READ: begin
          mem_R <= 1'b0;
          state <= a_we ? MERGE : EXTRACT;
        end
        EXTRACT: begin
          resp_rdata <= ld_val;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        MERGE: begin
          mem_din <= merged;
          mem_W   <= 1'b1;
          state   <= WRITE;
        end
        WRITE: begin
          mem_W      <= 1'b0;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          req_ready  <= 1'b1;
          state      <= IDLE;
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: scoreboard bench for load_store_unit with a
// behavioural word memory and a reference memory image.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic        mem_W;
  logic        mem_R;
  logic [31:0] mem_dout;

  load_store_unit dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_W(mem_W), .mem_R(mem_R), .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          acc;
    int          rd;
    int          wr;
    int          rd0;
    int          wr0;
  } exp_t;

  exp_t        q[$];
  exp_t        me;
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          rcnt = 0;
  int          wcnt = 0;
  logic [31:0] waddr = 32'd0;
  logic        mon_on = 1'b0;
  logic [31:0] last_rd = 32'd0;

  logic [31:0] mem [0:63];
  logic [31:0] ref_mem [0:63];
  logic        pl_en = 1'b0;
  logic [5:0]  pl_idx = 6'd0;
  logic [31:0] pl_val = 32'd0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (pl_en) mem[pl_idx] <= pl_val;
    else if (mem_W) mem[mem_addr[5:0]] <= mem_din;
    if (mem_R) mem_dout <= mem[mem_addr[5:0]];
    if (mem_R) rcnt <= rcnt + 1;
    if (mem_W) begin
      wcnt  <= wcnt + 1;
      waddr <= mem_addr;
    end
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      if (mem_R || mem_W)
        check("rw_excl", {31'd0, mem_R & mem_W}, 32'd0);
      if (resp_valid) begin
        if (q.size() == 0) begin
          check("unexp_resp", 32'd1, 32'd0);
        end else begin
          me = q.pop_front();
          check("lat", cyc - me.acc, me.lat);
          check("err", {31'd0, resp_err}, {31'd0, me.err});
          if (!me.err) check("rdata", resp_rdata, me.rdata);
          check("rd_cnt", rcnt - me.rd0, me.rd);
          check("wr_cnt", wcnt - me.wr0, me.wr);
        end
      end else begin
        check("err_idle", {31'd0, resp_err}, 32'd0);
      end
    end
  end

  function automatic logic misal(input logic [31:0] a,
                                 input logic [1:0] s);
`ifdef LSU_MISALIGN_TRAP_EN
    return (s == 2'b01 && a[0]) || (s == 2'b10 && a[1:0] != 2'b00)
           || s == 2'b11;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] ld_model(input logic [31:0] w,
    input logic [31:0] a, input logic [1:0] s, input logic u);
    logic [31:0] t;
    if (s == 2'b00) begin
      t = w >> (8 * a[1:0]);
      return u ? (t & 32'hFF) : {{24{t[7]}}, t[7:0]};
    end else if (s == 2'b01) begin
      t = w >> (16 * a[1]);
      return u ? (t & 32'hFFFF) : {{16{t[15]}}, t[15:0]};
    end
    return w;
  endfunction

  function automatic logic [31:0] st_model(input logic [31:0] w,
    input logic [31:0] a, input logic [1:0] s, input logic [31:0] d);
    logic [31:0] m;
    int sh;
    if (s == 2'b00) sh = 8 * a[1:0];
    else if (s == 2'b01) sh = 16 * a[1];
    else sh = 0;
    if (s == 2'b00) m = 32'hFF << sh;
    else if (s == 2'b01) m = 32'hFFFF << sh;
    else m = 32'hFFFF_FFFF;
    return (w & ~m) | ((d << sh) & m);
  endfunction

  task automatic set_word(input int idx, input logic [31:0] v);
    @(negedge clk);
    pl_idx = idx[5:0];
    pl_val = v;
    pl_en = 1'b1;
    ref_mem[idx] = v;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) check("ready_to", 32'd0, 32'd1);
  endtask

  task automatic txn(input logic we, input logic [1:0] s,
    input logic u, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    int idx;
    int n;
    logic bad;
    idx = int'(a[7:2]);
    bad = misal(a, s);
    wait_idle();
    e.acc = cyc;
    e.rd0 = rcnt;
    e.wr0 = wcnt;
    e.err = bad;
    e.rdata = last_rd;
    if (bad) begin
      e.lat = 1; e.rd = 0; e.wr = 0;
    end else if (!we) begin
      e.rdata = ld_model(ref_mem[idx], a, s, u);
      last_rd = e.rdata;
      e.lat = 3; e.rd = 1; e.wr = 0;
    end else if (s[1]) begin
      ref_mem[idx] = d;
      e.lat = 2; e.rd = 0; e.wr = 1;
    end else begin
      ref_mem[idx] = st_model(ref_mem[idx], a, s, d);
      e.lat = 4; e.rd = 1; e.wr = 1;
    end
    q.push_back(e);
    req_we = we;
    req_size = s;
    req_unsigned = u;
    req_addr = a;
    req_wdata = d;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    n = 0;
    while (q.size() > 0 && n < 12) begin
      @(negedge clk);
      n++;
    end
    if (q.size() > 0) begin
      check("resp_to", q.size(), 32'd0);
      q.delete();
    end
    if (we && !bad) check("mem", mem[idx], ref_mem[idx]);
  endtask

  initial begin
    int w0;
    rst = 1'b1;
    req_valid = 1'b1;
    req_we = 1'b0;
    req_size = 2'b10;
    req_unsigned = 1'b0;
    req_addr = 32'h10;
    req_wdata = 32'd0;
    for (int i = 0; i < 64; i++) set_word(i, $urandom);
    @(negedge clk);
    req_valid = 1'b0;
    check("rst_ready", {31'd0, req_ready}, 32'd1);
    check("rst_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_memr", {31'd0, mem_R}, 32'd0);
    check("rst_memw", {31'd0, mem_W}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    mon_on = 1'b1;

    set_word(5, 32'h8070_60F0);
    txn(1'b0, 2'b00, 1'b0, 32'h14, 32'd0);
    check("ldb_s", last_rd, 32'hFFFF_FFF0);
    txn(1'b0, 2'b01, 1'b1, 32'h16, 32'd0);
    check("ldh_u", last_rd, 32'h0000_8070);
    set_word(5, 32'h1122_3344);
    txn(1'b1, 2'b00, 1'b0, 32'h15, 32'h0000_00AB);
    check("stb_img", ref_mem[5], 32'h1122_AB44);
    txn(1'b1, 2'b10, 1'b0, 32'h20, 32'hDEAD_BEEF);
    check("stw_addr", waddr, 32'd8);
    txn(1'b0, 2'b10, 1'b0, 32'h22, 32'd0);
`ifndef LSU_MISALIGN_TRAP_EN
    check("ldw_force", last_rd, 32'hDEAD_BEEF);
`endif

    for (int i = 0; i < 30; i++)
      txn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
          1'($urandom_range(0, 1)),
          {24'd0, 6'($urandom_range(0, 15)), 2'($urandom_range(0, 3))},
          $urandom);

    set_word(5, 32'h1122_3344);
    wait_idle();
    w0 = wcnt;
    req_we = 1'b1;
    req_size = 2'b00;
    req_addr = 32'h15;
    req_wdata = 32'h55;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    last_rd = 32'd0;
    check("abort_ready", {31'd0, req_ready}, 32'd1);
    check("abort_valid", {31'd0, resp_valid}, 32'd0);
    check("abort_rdata", resp_rdata, 32'd0);
    repeat (6) @(negedge clk);
    check("abort_nowr", wcnt - w0, 32'd0);
    check("abort_mem", mem[5], 32'h1122_3344);
    txn(1'b0, 2'b00, 1'b1, 32'h15, 32'd0);
    check("post_abort", last_rd, 32'h0000_0033);

    check("q_empty", q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: `clk` and `rst`.
REQ-002 The block SHALL expose the following ports:
  clk  in  1  clock, all state on rising edge
  rst  in  1  synchronous active-high reset
  req_valid  in  1  CPU request present
  req_ready  out  1  unit idle, can accept
  req_we  in  1  1=store, 0=load
  req_size  in  2  00 byte, 01 halfword, 10 word, 11 reserved
  req_unsigned  in  1  1=zero-extend load, 0=sign-extend
  req_addr  in  32  byte address
  req_wdata  in  32  store data, right-aligned
  resp_valid  out  1  one-cycle completion pulse
  resp_rdata  out  32  extended load data
  resp_err  out  1  request rejected
  mem_addr  out  32  word index to data memory
  mem_din  out  32  write word to data memory
  mem_W  out  1  memory write strobe
  mem_R  out  1  memory read strobe
  mem_dout  in  32  memory read word, valid the cycle after mem_R

Function
REQ-003 Handshake: a request SHALL be accepted on a rising edge with req_valid=1 and req_ready=1; req_addr, req_wdata, req_size, req_we and req_unsigned SHALL be latched at that edge.
REQ-004 req_ready SHALL be 1 only in IDLE; a new request SHALL never be accepted while an operation is in flight.
REQ-005 mem_addr SHALL be {2'b00, latched_addr[31:2]}; mem_W and mem_R SHALL never both be 1.
REQ-006 Byte lanes SHALL be little-endian: byte k (addr[1:0]=k) occupies bits [8k+7:8k]; halfword at addr[1]=h occupies [16h+15:16h].
REQ-007 FSM states SHALL be IDLE, READ, EXTRACT, MERGE, WRITE, RESP.
REQ-008 Load SHALL follow IDLE->READ (mem_R=1)->EXTRACT (select lane, extend, register into resp_rdata)->RESP; resp_valid=1 in the 3rd cycle after accept.
REQ-009 Word store SHALL follow IDLE->WRITE (mem_W=1, mem_din=wdata)->RESP; resp_valid=1 in the 2nd cycle after accept.
REQ-010 Byte/halfword store SHALL follow IDLE->READ->MERGE (replace the addressed lane of mem_dout with the low bits of wdata, register it)->WRITE->RESP; resp_valid=1 in the 4th cycle after accept; all other lanes SHALL be unchanged.
REQ-011 RESP SHALL last exactly one cycle then return to IDLE; there is no response backpressure.
REQ-012 resp_rdata SHALL hold its last load value until the next load completes; for stores it SHALL be unchanged.
REQ-013 resp_err SHALL be valid only while resp_valid=1 and SHALL be 0 otherwise.

Reset
REQ-014 On rst=1 at a rising edge, the FSM SHALL go to IDLE, resp_valid=0, resp_err=0, resp_rdata=0, mem_W=0, mem_R=0 and req_ready=1 from the next cycle.
REQ-015 Reset mid-operation SHALL abort the operation with no response; a partially completed sub-word store (READ/MERGE) SHALL issue no write.
REQ-016 rst SHALL take priority over a simultaneous req_valid.

Configuration
REQ-017 With macro LSU_MISALIGN_TRAP_EN defined, a halfword with addr[0]=1, a word with addr[1:0]!=0, or req_size=11 SHALL go IDLE->RESP with resp_err=1, no mem_R/mem_W, and resp_valid in the 1st cycle after accept.
REQ-018 Without LSU_MISALIGN_TRAP_EN, the block SHALL force alignment (ignore addr[0] for halfwords and addr[1:0] for words), treat size 11 as word, and tie resp_err to 0.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
  - Memory word 5=0x8070_60F0; load byte, signed, addr 0x14 -> resp_rdata=0xFFFF_FFF0 at accept+3.
  - Same word; load halfword, unsigned, addr 0x16 -> resp_rdata=0x0000_8070.
  - Store byte 0xAB to addr 0x15 over word 0x1122_3344 -> memory=0x1122_AB44; mem_W exactly once, resp_valid at accept+4.
  - Store word 0xDEAD_BEEF to addr 0x20 -> mem_addr=8, mem_R never asserted, resp_valid at accept+2.
  - With trap enabled, load word at addr 0x22 -> resp_err=1 at accept+1, no memory strobes. Without trap, the same load -> reads word 8, resp_err=0.
  - rst asserted during MERGE of a byte store -> no mem_W, no resp_valid, req_ready=1 the cycle after reset.
